// File: rtl/hpu_axil_pkg.sv
// hpu_axil_pkg: shared state encoding and AXI4-Lite constants for the register master
package hpu_axil_pkg;
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [127:0] WSTRB_ALL = '1;
endpackage

// File: rtl/axil_reg_master.sv
// axil_reg_master: single-outstanding AXI4-Lite register initiator; define AXIL_MASTER_TIMEOUT_EN to abort stalled phases after TIMEOUT cycles
module axil_reg_master
  import hpu_axil_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic aw_done, w_done, aw_nx, w_nx, tmo;
  assign aw_nx = aw_done | (M_AXI_AWVALID & M_AXI_AWREADY);
  assign w_nx = w_done | (M_AXI_WVALID & M_AXI_WREADY);
  assign cmd_ready = (state == IDLE);
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA = data_q;
  assign M_AXI_WSTRB = WSTRB_ALL[DATA_W/8-1:0];
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt;
  logic adv;
  assign adv = (state == WADDR && aw_nx && w_nx) || (state == RADDR && M_AXI_ARREADY);
  assign tmo = (state != IDLE) && (state != RSP) && (tmo_cnt == CW'(TIMEOUT - 1));
  // phase watchdog: restarts on every phase entry, counts cycles spent waiting on the slave
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_cnt <= '0;
    else tmo_cnt <= (state == IDLE || state == RSP || adv) ? '0 : tmo_cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  // transaction sequencer: one outstanding access, every channel and response output registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q <= cmd_addr & ~ADDR_W'(3);
          data_q <= cmd_wdata;
          aw_done <= 1'b0;
          w_done <= 1'b0;
          rsp_rdata <= '0;
          rsp_err <= 1'b0;
          M_AXI_AWVALID <= cmd_write;
          M_AXI_WVALID <= cmd_write;
          M_AXI_ARVALID <= !cmd_write;
          state <= cmd_write ? WADDR : RADDR;
        end
        WADDR: begin
          aw_done <= aw_nx;
          w_done <= w_nx;
          M_AXI_AWVALID <= M_AXI_AWVALID && !M_AXI_AWREADY && !tmo;
          M_AXI_WVALID <= M_AXI_WVALID && !M_AXI_WREADY && !tmo;
          if (aw_nx && w_nx) begin
            M_AXI_BREADY <= 1'b1;
            state <= WRESP;
          end else if (tmo) begin
            rsp_err <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RSP;
          end
        end
        WRESP: if (M_AXI_BVALID || tmo) begin
          M_AXI_BREADY <= 1'b0;
          rsp_err <= !M_AXI_BVALID || (M_AXI_BRESP != RESP_OKAY);
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RADDR: if (M_AXI_ARREADY || tmo) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY <= M_AXI_ARREADY;
          rsp_err <= !M_AXI_ARREADY;
          rsp_valid <= !M_AXI_ARREADY;
          state <= M_AXI_ARREADY ? RDATA : RSP;
        end
        RDATA: if (M_AXI_RVALID || tmo) begin
          M_AXI_RREADY <= 1'b0;
          rsp_rdata <= M_AXI_RVALID ? M_AXI_RDATA : '0;
          rsp_err <= !M_AXI_RVALID || (M_AXI_RRESP != RESP_OKAY);
          rsp_valid <= 1'b1;
          state <= RSP;
        end
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_reg_master.sv
// tb_axil_reg_master: vector table, corner sequences and randomized accesses against a memory-backed AXI-Lite slave
module tb_axil_reg_master;
  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;

  axil_reg_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // slave knobs and state
  int aw_wait = 0, w_wait = 0, ar_wait = 0, rsp_wait = 0;
  logic [1:0] resp_code = 2'b00;
  logic stray_b = 1'b0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_tmr = 0, r_tmr = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic aw_got = 1'b0, w_got = 1'b0, s_bvalid = 1'b0, s_rvalid = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_rdata = '0, wr_addr, wr_data;
  logic [3:0] s_wstrb = '0;
  logic [31:0] smem [0:15];
  logic [31:0] mdl [0:15];
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign awready = (aw_cnt >= aw_wait);
  assign wready = (w_cnt >= w_wait);
  assign arready = (ar_cnt >= ar_wait);
  assign bvalid = s_bvalid | stray_b;
  assign rvalid = s_rvalid;
  assign bresp = resp_code;
  assign rresp = resp_code;
  assign rdata = s_rdata;
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign b_hs = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs = rvalid & rready;
  assign wr_addr = aw_hs ? awaddr : s_awaddr;
  assign wr_data = w_hs ? wdata : s_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_tmr <= 0; r_tmr <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (aw_hs) begin s_awaddr <= awaddr; n_aw <= n_aw + 1; end
      if (w_hs) begin s_wdata <= wdata; s_wstrb <= wstrb; n_w <= n_w + 1; end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        smem[wr_addr[5:2]] <= wr_data;
        if (rsp_wait == 0) s_bvalid <= 1'b1; else b_tmr <= rsp_wait;
      end else begin
        aw_got <= aw_got | aw_hs; w_got <= w_got | w_hs;
      end
      if (b_tmr > 0) begin b_tmr <= b_tmr - 1; if (b_tmr == 1) s_bvalid <= 1'b1; end
      if (b_hs) begin s_bvalid <= 1'b0; n_b <= n_b + 1; end
      if (ar_hs) begin
        s_rdata <= smem[araddr[5:2]]; n_ar <= n_ar + 1;
        if (rsp_wait == 0) s_rvalid <= 1'b1; else r_tmr <= rsp_wait;
      end
      if (r_tmr > 0) begin r_tmr <= r_tmr - 1; if (r_tmr == 1) s_rvalid <= 1'b1; end
      if (r_hs) begin s_rvalid <= 1'b0; n_r <= n_r + 1; end
    end
  end

  // protocol watch: a VALID that was waiting on READY must still be up one cycle later
  logic mon_en = 1'b1, p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (p_aw) chk("awvalid_held", awvalid, 1);
      if (p_w) chk("wvalid_held", wvalid, 1);
      if (p_ar) chk("arvalid_held", arvalid, 1);
    end
    p_aw <= awvalid && !awready;
    p_w <= wvalid && !wready;
    p_ar <= arvalid && !arready;
  end

  task automatic txn(input string nm, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input int aw_w, input int w_w, input int ar_w, input int rw, input logic [1:0] code,
                     input int hold, input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int n, naw0, nw0, nb0, nar0, nr0;
    aw_wait = aw_w; w_wait = w_w; ar_wait = ar_w; rsp_wait = rw; resp_code = code;
    naw0 = n_aw; nw0 = n_w; nb0 = n_b; nar0 = n_ar; nr0 = n_r;
    @(negedge clk);
    chk({nm, ".cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; rsp_ready = 1'b0;
    n = 1;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      n++;
    end while (!rsp_valid && n < 300);
    chk({nm, ".latency"}, n, exp_lat);
    for (int h = 0; h < hold; h++) begin
      chk({nm, ".rsp_hold"}, {rsp_valid, cmd_ready, rsp_err, rsp_rdata}, {1'b1, 1'b0, exp_err, exp_rd});
      @(negedge clk);
    end
    chk({nm, ".rdata"}, rsp_rdata, exp_rd);
    chk({nm, ".err"}, rsp_err, exp_err);
    chk({nm, ".cmd_ready_busy"}, cmd_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, ".rsp_done"}, {rsp_valid, cmd_ready}, 2'b01);
    chk({nm, ".handshakes"}, {8'(n_aw - naw0), 8'(n_w - nw0), 8'(n_b - nb0), 8'(n_ar - nar0), 8'(n_r - nr0)},
        wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
    if (wr) chk({nm, ".aw_w_beats"}, {s_awaddr, s_wdata, s_wstrb}, {addr & ~32'h3, data, 4'hF});
  endtask

  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] data;
    int aw_w; int w_w; int ar_w; int rw; logic [1:0] code; int hold;
    logic [31:0] exp_rd; logic exp_err; int exp_lat;
  } vec_t;
  vec_t tv [6];

  initial begin
    logic wr;
    logic [1:0] code;
    logic [31:0] addr, data;
    int a, w, ar, r, n;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; mdl[i] = '0; end
    tv[0] = '{1'b1, 32'h0,  32'h2,         0, 0, 0, 0, 2'b00, 0, 32'h0,         1'b0, 4};
    tv[1] = '{1'b0, 32'h0,  32'h0,         0, 0, 0, 3, 2'b00, 0, 32'h2,         1'b0, 7};
    tv[2] = '{1'b1, 32'h7,  32'hDEADBEEF,  0, 2, 0, 0, 2'b00, 0, 32'h0,         1'b0, 6};
    tv[3] = '{1'b0, 32'h4,  32'h0,         0, 0, 0, 0, 2'b10, 5, 32'hDEADBEEF,  1'b1, 4};
    tv[4] = '{1'b0, 32'h7,  32'h0,         0, 0, 2, 0, 2'b00, 0, 32'hDEADBEEF,  1'b0, 6};
    tv[5] = '{1'b1, 32'h3C, 32'h12345678,  3, 1, 0, 1, 2'b11, 0, 32'h0,         1'b1, 8};
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_handshake_outs", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err}, 0);
    chk("reset_data_outs", {rsp_rdata, awaddr, araddr, wdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      txn($sformatf("tv%0d", i), tv[i].wr, tv[i].addr, tv[i].data, tv[i].aw_w, tv[i].w_w, tv[i].ar_w,
          tv[i].rw, tv[i].code, tv[i].hold, tv[i].exp_rd, tv[i].exp_err, tv[i].exp_lat);
      if (tv[i].wr) mdl[tv[i].addr[5:2]] = tv[i].data;
    end
    stray_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_bvalid_ignored", {bready, rsp_valid, cmd_ready}, 3'b001);
    end
    stray_b = 1'b0;
    mon_en = 1'b0; aw_wait = 0; w_wait = 0; rsp_wait = 30; resp_code = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A50001;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!bready && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_reach_wresp", bready, 1);
    mdl[4] = 32'hA5A50001;
    rst = 1'b1;
    #1;
    chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
    end
    mon_en = 1'b1;
    txn("post_rst_wr", 1'b1, 32'h14, 32'h0BADF00D, 0, 0, 0, 0, 2'b00, 0, 32'h0, 1'b0, 4);
    mdl[5] = 32'h0BADF00D;
    txn("post_rst_rd", 1'b0, 32'h10, 32'h0, 0, 0, 0, 0, 2'b00, 0, mdl[4], 1'b0, 4);
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 63));
      data = $urandom;
      a = $urandom_range(0, 4); w = $urandom_range(0, 4);
      ar = $urandom_range(0, 4); r = $urandom_range(0, 4);
      code = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      txn($sformatf("rnd%0d", i), wr, addr, data, a, w, ar, r, code, $urandom_range(0, 2),
          wr ? 32'h0 : mdl[addr[5:2]], code != 2'b00, wr ? 4 + (a > w ? a : w) + r : 4 + ar + r);
      if (wr) mdl[addr[5:2]] = data;
    end
`ifdef AXIL_MASTER_TIMEOUT_EN
    mon_en = 1'b0; ar_wait = 1000; rsp_wait = 0; resp_code = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (arvalid && n < 100) begin n++; @(negedge clk); end
    chk("tmo_arvalid_cycles", n, 8);
    chk("tmo_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("tmo_back_idle", {rsp_valid, cmd_ready, arvalid}, 3'b010);
    ar_wait = 0; mon_en = 1'b1;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
